// File: rtl/rom_stream_reader.sv
// rom_stream_reader: sequences reads from the combinational lab ROM.
// It drives the ROM address, OE and CS_n pins, captures each word and
// presents it on a valid/ready stream. Reads len consecutive words from
// start_addr, wrapping around the top of the address space.
// Optional feature: define ROM_STREAM_CHECKSUM_EN to add a running
// modulo-2^data_size checksum output over the words handed downstream.
module rom_stream_reader #(
  parameter int data_size = 8,
  parameter int addr_bits = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [addr_bits-1:0] start_addr,
  input  logic [addr_bits:0]   len,
  output logic [addr_bits-1:0] rom_addr,
  output logic                 rom_oe,
  output logic                 rom_cs_n,
  input  logic [data_size-1:0] rom_data,
  output logic [data_size-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
`ifdef ROM_STREAM_CHECKSUM_EN
  ,
  output logic [data_size-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CAPTURE,
    OUTPUT,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [addr_bits-1:0] rom_addr_q, rom_addr_d;
  logic                 rom_oe_q, rom_oe_d;
  logic                 rom_cs_n_q, rom_cs_n_d;
  logic [data_size-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [addr_bits:0]   remaining_q, remaining_d;
`ifdef ROM_STREAM_CHECKSUM_EN
  logic [data_size-1:0] checksum_q, checksum_d;
`endif

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    rom_oe_d    = rom_oe_q;
    rom_cs_n_d  = rom_cs_n_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    remaining_d = remaining_q;
`ifdef ROM_STREAM_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          rom_addr_d  = start_addr;
          remaining_d = len;
`ifdef ROM_STREAM_CHECKSUM_EN
          checksum_d  = '0;
`endif
          if (len == '0) begin
            state_d = DONE;
          end else begin
            state_d    = SETUP;
            rom_cs_n_d = 1'b0;
            rom_oe_d   = 1'b1;
          end
        end
      end

      SETUP: begin
        state_d = CAPTURE;
      end

      CAPTURE: begin
        out_data_d  = rom_data;
        out_valid_d = 1'b1;
        rom_cs_n_d  = 1'b1;
        rom_oe_d    = 1'b0;
        state_d     = OUTPUT;
      end

      OUTPUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          remaining_d = remaining_q - 1'b1;
`ifdef ROM_STREAM_CHECKSUM_EN
          checksum_d  = checksum_q + out_data_q;
`endif
          if (remaining_q == (addr_bits + 1)'(1)) begin
            state_d = DONE;
          end else begin
            rom_addr_d = rom_addr_q + 1'b1;
            rom_cs_n_d = 1'b0;
            rom_oe_d   = 1'b1;
            state_d    = SETUP;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      rom_oe_q    <= 1'b0;
      rom_cs_n_q  <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
`ifdef ROM_STREAM_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      rom_oe_q    <= rom_oe_d;
      rom_cs_n_q  <= rom_cs_n_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
`ifdef ROM_STREAM_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rom_oe    = rom_oe_q;
  assign rom_cs_n  = rom_cs_n_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef ROM_STREAM_CHECKSUM_EN
  assign checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Testbench for rom_stream_reader. A behavioural ROM array feeds the DUT;
// each transfer's expected word list, address sequence, timing and
// checksum are derived from the ROM contents with plain arithmetic.
// Checksum checks are compiled only when ROM_STREAM_CHECKSUM_EN is defined.
module tb_rom_stream_reader;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] rom_addr;
  logic          rom_oe;
  logic          rom_cs_n;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;
`ifdef ROM_STREAM_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] rom_mem [DEPTH];
  int total = 0;
  int bad   = 0;

  rom_stream_reader #(.data_size(DW), .addr_bits(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .rom_addr   (rom_addr),
    .rom_oe     (rom_oe),
    .rom_cs_n   (rom_cs_n),
    .rom_data   (rom_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
`ifdef ROM_STREAM_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Combinational ROM; a distinctive float value appears while it is deselected.
  assign rom_data = (!rom_cs_n && rom_oe) ? rom_mem[rom_addr] : 8'h5A;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_cs_n"}, 32'(rom_cs_n), 1);
    checkOutput({tag, "_oe"}, 32'(rom_oe), 0);
    checkOutput({tag, "_valid"}, 32'(out_valid), 0);
  endtask

  // One transfer: readyMode 0 = always ready, 1 = random, 2 = 5-cycle stall on first word.
  task automatic applyStimulus(input int sa, input int ln, input int readyMode, input bit pokeStart);
    logic [DW-1:0] expQ[$];
    int sum;
    int k;
    int idx;
    int wordStart;
    int expDoneK;
    int stallCnt;
    bit doneSeen;
    bit csSeen;
    bit validSeen;
    bit rdy;

    sum = 0;
    for (int i = 0; i < ln; i++) begin
      expQ.push_back(rom_mem[(sa + i) % DEPTH]);
      sum += int'(rom_mem[(sa + i) % DEPTH]);
    end

    @(negedge clk);
    start      = 1'b1;
    start_addr = AW'(sa);
    len        = (AW + 1)'(ln);
    out_ready  = 1'b0;
    @(negedge clk);
    start = 1'b0;

    k         = 0;
    idx       = 0;
    wordStart = 0;
    expDoneK  = (ln == 0) ? 0 : -1;
    stallCnt  = 0;
    doneSeen  = 1'b0;
    csSeen    = 1'b0;
    validSeen = 1'b0;
`ifdef ROM_STREAM_CHECKSUM_EN
    checkOutput("checksum_cleared", 32'(checksum), 0);
`endif

    while (!doneSeen && k < 600) begin
      if (done) begin
        checkOutput("done_cycle", 32'(k), 32'(expDoneK));
        checkOutput("handshakes", 32'(idx), 32'(ln));
        checkOutput("cs_used", 32'(csSeen), 32'(ln != 0));
        checkOutput("done_busy", 32'(busy), 1);
`ifdef ROM_STREAM_CHECKSUM_EN
        checkOutput("checksum_done", 32'(checksum), 32'(sum % 256));
`endif
        doneSeen = 1'b1;
      end else begin
        checkOutput("busy", 32'(busy), 1);
        if (!rom_cs_n) begin
          csSeen = 1'b1;
          checkOutput("rom_addr", 32'(rom_addr), 32'((sa + idx) % DEPTH));
          checkOutput("rom_oe_on", 32'(rom_oe), 1);
        end else begin
          checkOutput("rom_oe_off", 32'(rom_oe), 0);
        end
        if (out_valid) begin
          checkOutput("cs_during_output", 32'(rom_cs_n), 1);
          if (!validSeen) checkOutput("valid_latency", 32'(k), 32'(wordStart + 2));
          validSeen = 1'b1;
          if (idx < ln) checkOutput("out_data", 32'(out_data), 32'(expQ[idx]));
          else checkOutput("extra_word", 32'(idx), 32'(ln));
          case (readyMode)
            0: rdy = 1'b1;
            1: rdy = ($urandom_range(0, 3) != 0);
            default: begin
              if (idx == 0 && stallCnt < 5) begin
                rdy = 1'b0;
                stallCnt++;
              end else begin
                rdy = 1'b1;
              end
            end
          endcase
          out_ready = rdy;
          if (pokeStart && $urandom_range(0, 1) == 1) begin
            start      = 1'b1;
            start_addr = AW'($urandom_range(0, DEPTH - 1));
            len        = (AW + 1)'($urandom_range(1, DEPTH));
          end
          if (rdy) begin
            idx++;
            wordStart = k + 1;
            validSeen = 1'b0;
            if (idx == ln) expDoneK = k + 1;
          end
        end else begin
          if (validSeen) checkOutput("valid_dropped", 0, 1);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      if (!doneSeen) begin
        @(negedge clk);
        start = 1'b0;
        k++;
      end
    end
    checkOutput("timeout", 32'(doneSeen), 1);
    if (readyMode == 2 && ln > 0) checkOutput("stall_cycles", 32'(stallCnt), 5);

    @(negedge clk);
    out_ready = 1'b0;
    checkIdle("after_done");
`ifdef ROM_STREAM_CHECKSUM_EN
    checkOutput("checksum_hold", 32'(checksum), 32'(sum % 256));
`endif
  endtask

  // Start a transfer, then hold reset for two cycles mid-flight.
  task automatic resetMidTransfer();
    int doneCnt;
    @(negedge clk);
    start      = 1'b1;
    start_addr = 5'd3;
    len        = 6'd6;
    out_ready  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midflight_busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkIdle("reset_mid");
    checkOutput("reset_addr", 32'(rom_addr), 0);
    checkOutput("reset_data", 32'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) doneCnt++;
    end
    checkOutput("no_done_after_abort", 32'(doneCnt), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = DW'(i * 3);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    checkOutput("reset_addr", 32'(rom_addr), 0);
    checkOutput("reset_data", 32'(out_data), 0);
`ifdef ROM_STREAM_CHECKSUM_EN
    checkOutput("reset_checksum", 32'(checksum), 0);
`endif
    rst_n = 1'b1;

    $display("[TB] basic read");
    applyStimulus(4, 3, 0, 1'b0);
    $display("[TB] wrap-around");
    applyStimulus(30, 4, 0, 1'b0);
    $display("[TB] backpressure");
    applyStimulus(7, 2, 2, 1'b0);
    $display("[TB] zero length");
    applyStimulus(9, 0, 0, 1'b0);
    $display("[TB] full depth with ignored starts");
    applyStimulus(13, 32, 0, 1'b1);

    rom_mem[0] = 8'h80;
    rom_mem[1] = 8'h90;
    rom_mem[2] = 8'h10;
    rom_mem[3] = 8'h05;
    $display("[TB] checksum pattern and restart");
    applyStimulus(0, 4, 1, 1'b0);
    applyStimulus(2, 2, 0, 1'b0);

    $display("[TB] reset mid-transfer");
    resetMidTransfer();

    $display("[TB] randomized transfers");
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < DEPTH; i++) rom_mem[i] = DW'($urandom);
      applyStimulus($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
